c17_resp_checker: RTL and testbench
===================================

# c17_resp_checker

Response-side companion to the c17 stimulus sweep: it watches the five c17 input pins as they are applied, computes the golden c17 outputs, aligns them with the DUT's registered outputs N22q/N23q2, and reports pass/fail, mismatch count, first failing vector index and a 16-bit MISR signature. It sits beside the c17 instance in bench or BIST wrappers, so that the exhaustive 32-vector sweep is self-checking rather than waveform-inspected.

## Interface
Parameters:
- LATENCY, 1, clock cycles from stimulus applied (vec_valid sampled) to the matching DUT output being valid; legal 0..4
- NUM_VEC, 32, vectors per sweep; fixed at 32 (5-bit index)
- MISR_POLY, 16'h1021, MISR feedback polynomial (x^16 term implicit)

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin or restart a sweep (single-cycle pulse)
- vec_valid  in  1  N1..N7 carry a newly applied vector this cycle
- N1, N2, N3, N6, N7  in  1 each  stimulus as applied to c17
- N22q, N23q2  in  1 each  DUT outputs
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  6  mismatched vectors, saturating at 63
- first_err_valid  out  1  at least one mismatch seen
- first_err_idx  out  5  index of the first mismatched vector
- signature  out  16  MISR state

## Operation
- Golden model, per vector: n10=NAND(N1,N3), n11=NAND(N3,N6), n16=NAND(N2,n11), n19=NAND(n11,N7), exp22=NAND(n10,n16), exp23=NAND(n16,n19).
- FSM: IDLE -> RUN on start; RUN -> DONE when the 32nd compare executes; DONE -> RUN on start. start in RUN is ignored.
- On entering RUN: err_count, first_err_*, the vector index and the accepted/compared counters all clear, and signature loads 16'hFFFF.
- In RUN, vec_valid accepts a vector until 32 have been accepted; further vec_valid is ignored. vec_valid in IDLE or DONE is ignored.
- Each accepted vector pushes {valid, idx, exp22, exp23} into a LATENCY-deep delay line. When the delayed valid emerges, the block performs one compare:
  - mismatch = (N22q!=exp22) | (N23q2!=exp23)
  - on mismatch, err_count increments (saturating); if first_err_valid is low, it latches the index and sets first_err_valid
  - signature <= {sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0) ^ {14'b0, N23q2, N22q}
- Vector spacing is arbitrary: back-to-back, or gapped as in the 2-clock bench stepping.

## Timing
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, signature=16'hFFFF, FSM=IDLE, delay line empty.
- Compare for the vector accepted at cycle t happens at cycle t+LATENCY. For LATENCY=0 it uses the DUT outputs in the same cycle.
- Outputs are registered. done, pass, the final err_count and signature are visible the cycle after the 32nd compare.
- rst has priority over start, and start over vec_valid. rst mid-sweep aborts to IDLE and flushes the delay line.
- start in DONE in the same cycle as vec_valid: state clears, and that vec_valid is not accepted.
- err_count saturates at 63 (unreachable with 32 vectors; retained for robustness).

## Structure
- Shared package c17_pkg: FSM state enum (IDLE/RUN/DONE), NUM_VEC, MISR_POLY/MISR_SEED constants, and a c17_golden function reused by stimulus-side blocks.
- One natural sub-module: c17_misr (16-bit MISR with load/enable). FSM, counters and delay line stay in the top.

## Test plan
- Exhaustive sweep through a correct registered c17, LATENCY=1, vectors every 2 clocks, in the bench order (N7..N1 counting 0..31) -> done=1, pass=1, err_count=0, first_err_valid=0. Signature matches the model value.
- Same sweep with N22q inverted only on vector index 5 -> err_count=1, first_err_idx=5, pass=0. Signature differs from the clean run.
- Vector 0 (all zeros) expects 00 and vector 5 (N3=1, N1=1) expects N22q=1, N23q2=0. Force N22q=0 permanently -> first_err_idx is the lowest index with exp22=1.
- rst asserted after 10 accepted vectors -> all outputs at reset values next cycle. A new start plus 32 vectors passes cleanly.
- LATENCY=0 with back-to-back vectors, plus extra vec_valid after 32 -> exactly 32 compares, extras ignored, done one cycle after the last compare.
- start in RUN ignored; start in DONE restarts with signature=16'hFFFF and counters cleared.

Source files
------------

// File: rtl/c17_pkg.sv
// Shared types and constants for the c17 response checker.
// Also provides the golden c17 function for stimulus-side blocks.
package c17_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NUM_VEC = 32;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
    logic       e22;
    logic       e23;
  } tag_t;

  function automatic logic [1:0] c17_golden(
    input logic n1,
    input logic n2,
    input logic n3,
    input logic n6,
    input logic n7
  );
    logic n10, n11, n16, n19;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// 16-bit MISR compacting the two c17 outputs per compare.
// load reseeds, en folds in one response word.
module c17_misr
  import c17_pkg::*;
#(
  parameter logic [15:0] POLY = MISR_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0}
           ^ (sig[15] ? POLY : 16'h0000)
           ^ {14'b0, din};
    end
  end

endmodule

// File: rtl/c17_resp_checker.sv
// Golden-model response checker for the c17 32-vector sweep.
// Aligns expectations to DUT outputs through a LATENCY-deep tag line.
module c17_resp_checker #(
  parameter int          LATENCY   = 1,
  parameter int          NUM_VEC   = 32,
  parameter logic [15:0] MISR_POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        vec_valid,
  input  logic        N1,
  input  logic        N2,
  input  logic        N3,
  input  logic        N6,
  input  logic        N7,
  input  logic        N22q,
  input  logic        N23q2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic        first_err_valid,
  output logic [4:0]  first_err_idx,
  output logic [15:0] signature
);

  import c17_pkg::*;

  state_t     state, state_nx;
  logic [5:0] acc_cnt, cmp_cnt;
  logic       go, acc, cmp, mis, last;
  logic [1:0] gold;
  tag_t       tag_in, tag_out;

  assign go   = start && (state != RUN);
  assign acc  = (state == RUN) && vec_valid
             && (acc_cnt < 6'(NUM_VEC));
  assign gold = c17_golden(N1, N2, N3, N6, N7);

  assign tag_in = {acc, acc_cnt[4:0], gold};

  generate
    if (LATENCY == 0) begin : g_l0
      assign tag_out = tag_in;
    end else begin : g_dl
      tag_t dl [LATENCY];
      always_ff @(posedge clk) begin
        if (rst || go) begin
          for (int i = 0; i < LATENCY; i++)
            dl[i] <= '0;
        end else begin
          dl[0] <= tag_in;
          for (int i = 1; i < LATENCY; i++)
            dl[i] <= dl[i-1];
        end
      end
      assign tag_out = dl[LATENCY-1];
    end
  endgenerate

  assign cmp  = tag_out.vld && (state == RUN);
  assign mis  = (N22q != tag_out.e22)
             || (N23q2 != tag_out.e23);
  assign last = cmp && (cmp_cnt == 6'(NUM_VEC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (err_count == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || go) begin
      acc_cnt         <= '0;
      cmp_cnt         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      if (acc) acc_cnt <= acc_cnt + 6'd1;
      if (cmp) begin
        cmp_cnt <= cmp_cnt + 6'd1;
        if (mis) begin
          if (err_count != 6'd63)
            err_count <= err_count + 6'd1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= tag_out.idx;
          end
        end
      end
    end
  end

  c17_misr #(
    .POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .en   (cmp),
    .din  ({N23q2, N22q}),
    .sig  (signature)
  );

endmodule

// File: tb/tb_c17_resp_checker.sv
// Bench for c17_resp_checker: LATENCY=1 and LATENCY=0 instances
// share stimulus; a sweep-level model predicts every result.
module tb_c17_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, vec_valid;
  logic n1, n2, n3, n6, n7;
  logic f22, f23;
  logic c22, c23, q22, q23;

  logic        busy1, done1, pass1, fev1;
  logic [5:0]  err1;
  logic [4:0]  fidx1;
  logic [15:0] sig1;
  logic        busy0, done0, pass0, fev0;
  logic [5:0]  err0;
  logic [4:0]  fidx0;
  logic [15:0] sig0;

  int errors = 0;
  int checks = 0;

  logic [4:0] vecs  [32];
  logic [1:0] flips [32];

  // v = {N7,N6,N3,N2,N1}; returns {out22,out23}
  function automatic logic [1:0] ref_out(input logic [4:0] v);
    logic a, b, c, d, e;
    {e, d, c, b, a} = v;
    ref_out[1] = (a & c) | (b & ~(c & d));
    ref_out[0] = ~(c & d) & (b | e);
  endfunction

  assign {c22, c23} = ref_out({n7, n6, n3, n2, n1}) ^ {f22, f23};

  always @(posedge clk) begin
    q22 <= c22;
    q23 <= c23;
  end

  c17_resp_checker #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .N22q(q22), .N23q2(q23),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_idx(fidx1), .signature(sig1)
  );

  c17_resp_checker #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .N22q(c22), .N23q2(c23),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fev0), .first_err_idx(fidx0), .signature(sig0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [1:0] f);
    {n7, n6, n3, n2, n1} = v;
    {f22, f23} = f;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_busy1"}, busy1, 0);  chk({p, "_busy0"}, busy0, 0);
    chk({p, "_done1"}, done1, 0);  chk({p, "_done0"}, done0, 0);
    chk({p, "_pass1"}, pass1, 0);  chk({p, "_pass0"}, pass0, 0);
    chk({p, "_err1"}, err1, 0);    chk({p, "_err0"}, err0, 0);
    chk({p, "_fev1"}, fev1, 0);    chk({p, "_fev0"}, fev0, 0);
    chk({p, "_fidx1"}, fidx1, 0);  chk({p, "_fidx0"}, fidx0, 0);
    chk({p, "_sig1"}, sig1, 16'hFFFF);
    chk({p, "_sig0"}, sig0, 16'hFFFF);
  endtask

  // Model results of the most recent sweep
  int          m_err;
  logic        m_fev;
  int          m_fidx;
  logic [15:0] m_sig;

  task automatic model();
    logic [1:0] e, o;
    m_err = 0; m_fev = 0; m_fidx = 0; m_sig = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      e = ref_out(vecs[k]);
      o = e ^ flips[k];
      if (o != e) begin
        m_err++;
        if (!m_fev) begin
          m_fev = 1;
          m_fidx = k;
        end
      end
      m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0)
            ^ {14'b0, o[0], o[1]};
    end
  endtask

  // mode: 0 clean, 1 flip N22 on idx5, 2 force N22=0, 3 random
  // gap: >=0 fixed idle cycles, <0 random 0..3
  task automatic sweep(input string p, input int mode, input int gap,
                       input bit rnd, input int smid, input bit extra);
    logic [1:0] e;
    int g;
    for (int k = 0; k < 32; k++) begin
      vecs[k] = rnd ? 5'($urandom) : 5'(k);
      e = ref_out(vecs[k]);
      case (mode)
        0: flips[k] = 2'b00;
        1: flips[k] = (k == 5) ? 2'b10 : 2'b00;
        2: flips[k] = {e[1], 1'b0};
        default: flips[k] = ($urandom_range(0, 5) == 0)
                            ? 2'($urandom) : 2'b00;
      endcase
    end
    model();
    // start with a junk vector that must not be taken
    drive(5'($urandom), 2'b11);
    start = 1; vec_valid = 1;
    tick();
    start = 0; vec_valid = 0;
    chk({p, "_st_busy1"}, busy1, 1);
    chk({p, "_st_sig1"}, sig1, 16'hFFFF);
    chk({p, "_st_err0"}, err0, 0);
    chk({p, "_st_fev0"}, fev0, 0);
    for (int k = 0; k < 32; k++) begin
      drive(vecs[k], flips[k]);
      vec_valid = 1;
      start = (k == smid);
      tick();
      vec_valid = 0;
      start = 0;
      if (k == 31) begin
        chk({p, "_l0_done_now"}, done0, 1);
        chk({p, "_l1_busy_now"}, busy1, 1);
      end
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) tick();
    end
    if (extra) begin
      drive(5'($urandom), 2'b11);
      vec_valid = 1;
      repeat (3) tick();
      vec_valid = 0;
    end
    for (int i = 0; i < 10 && !(done1 && done0); i++) tick();
    chk({p, "_done1"}, done1, 1);
    chk({p, "_done0"}, done0, 1);
    chk({p, "_err1"}, err1, 6'(m_err));
    chk({p, "_err0"}, err0, 6'(m_err));
    chk({p, "_fev1"}, fev1, m_fev);
    chk({p, "_fev0"}, fev0, m_fev);
    chk({p, "_fidx1"}, fidx1, m_fev ? 5'(m_fidx) : 5'd0);
    chk({p, "_fidx0"}, fidx0, m_fev ? 5'(m_fidx) : 5'd0);
    chk({p, "_pass1"}, pass1, (m_err == 0));
    chk({p, "_pass0"}, pass0, (m_err == 0));
    chk({p, "_sig1"}, sig1, m_sig);
    chk({p, "_sig0"}, sig0, m_sig);
  endtask

  typedef struct {
    string nm;
    int    mode;
    int    gap;
    int    smid;
    bit    extra;
    int    e_err;
    bit    e_fev;
    int    e_fidx;
    bit    e_pass;
  } row_t;

  row_t rows [4];

  initial begin
    rows[0] = '{"clean",   0, 1, -1, 0, 0,  0, 0, 1};
    rows[1] = '{"inj5",    1, 1, -1, 0, 1,  1, 5, 0};
    rows[2] = '{"force0",  2, 1, -1, 0, 18, 1, 2, 0};
    rows[3] = '{"b2b",     0, 0, 12, 1, 0,  0, 0, 1};

    rst = 1; start = 0; vec_valid = 0;
    drive(5'd0, 2'b00);
    repeat (2) tick();
    chk_idle("reset");
    start = 1;
    tick();
    rst = 0; start = 0;
    chk("rst_over_start", busy1, 0);

    for (int r = 0; r < 4; r++) begin
      sweep(rows[r].nm, rows[r].mode, rows[r].gap, 0,
            rows[r].smid, rows[r].extra);
      chk({rows[r].nm, "_tbl_err"}, err1, 6'(rows[r].e_err));
      chk({rows[r].nm, "_tbl_fev"}, fev1, rows[r].e_fev);
      chk({rows[r].nm, "_tbl_fidx"}, fidx1, 5'(rows[r].e_fidx));
      chk({rows[r].nm, "_tbl_pass"}, pass1, rows[r].e_pass);
    end

    for (int r = 0; r < 4; r++)
      sweep($sformatf("rnd%0d", r), 3, -1, 1,
            $urandom_range(0, 40), 1);

    // abort mid-sweep after 10 accepted, all-mismatching vectors
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 10; k++) begin
      drive(5'(k), 2'b11);
      vec_valid = 1;
      tick();
    end
    vec_valid = 0;
    tick();
    chk("pre_rst_err1", err1, 6'd10);
    rst = 1;
    tick();
    rst = 0;
    chk_idle("abort");

    sweep("post_rst", 0, 1, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
